// File: rtl/midi_reg_master.sv
// midi_reg_master: decodes a MIDI byte stream into floppy control register
// writes. Note On/Off on two configured channels become single-cycle write
// requests; MIDI System Reset (0xFF) emits an "all off" write pair.
module midi_reg_master #(
  parameter logic [3:0] FLOPPY0_CH = 4'd0,
  parameter logic [3:0] FLOPPY1_CH = 4'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       new_rx_data,
  output logic [5:0] reg_addr,
  output logic       write,
  output logic       new_req,
  output logic [7:0] write_value
);

  // Parser states. PANIC0 is the cycle in which the floppy 0 off-write is
  // presented on the outputs; PANIC1 is the cycle for the floppy 1 off-write.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_NOTE   = 3'd1,
    ST_VEL    = 3'd2,
    ST_SKIP   = 3'd3,
    ST_PANIC0 = 3'd4,
    ST_PANIC1 = 3'd5
  } state_t;

  // 0xF8..0xFE: realtime bytes, transparent to the parser.
  function automatic logic is_realtime(input logic [7:0] b);
    return (b[7:3] == 5'b11111) && (b != 8'hFF);
  endfunction

  // 0xF0..0xF7: system common / exclusive, cancels running status.
  function automatic logic is_sys_common(input logic [7:0] b);
    return (b[7:3] == 5'b11110);
  endfunction

  // 0x8n / 0x9n: Note Off / Note On channel status.
  function automatic logic is_note_status(input logic [7:0] b);
    return (b[7:5] == 3'b100);
  endfunction

  state_t          state_r, state_nxt_s;
  logic            kind_r, kind_nxt_s;        // 1 = Note On, 0 = Note Off
  logic            tgt_r, tgt_nxt_s;          // target floppy index
  logic [6:0]      note_r, note_nxt_s;        // note byte of message in flight
  logic [1:0][6:0] cur_note_r, cur_note_nxt_s;
  logic [1:0]      cur_en_r, cur_en_nxt_s;
  logic            req_s;
  logic [5:0]      addr_s;
  logic [7:0]      val_s;
  logic            vel_on_s;

  // Next-state, tracked-note update and request generation.
  always_comb begin
    state_nxt_s    = state_r;
    kind_nxt_s     = kind_r;
    tgt_nxt_s      = tgt_r;
    note_nxt_s     = note_r;
    cur_note_nxt_s = cur_note_r;
    cur_en_nxt_s   = cur_en_r;
    req_s          = 1'b0;
    addr_s         = reg_addr;
    val_s          = write_value;
    vel_on_s       = kind_r && (rx_data[6:0] != 7'd0);

    case (state_r)
      ST_PANIC0: begin
        // Floppy 0 off-write is on the outputs now; queue floppy 1.
        req_s       = 1'b1;
        addr_s      = 6'h01;
        val_s       = 8'h00;
        state_nxt_s = ST_PANIC1;
      end

      ST_PANIC1: begin
        // Incoming bytes are dropped for the whole panic sequence.
        state_nxt_s = ST_IDLE;
      end

      ST_IDLE, ST_NOTE, ST_VEL, ST_SKIP: begin
        if (new_rx_data) begin
          if (rx_data == 8'hFF) begin
            // System Reset: first off-write goes out right away.
            req_s        = 1'b1;
            addr_s       = 6'h00;
            val_s        = 8'h00;
            cur_en_nxt_s = 2'b00;
            state_nxt_s  = ST_PANIC0;
          end else if (is_realtime(rx_data)) begin
            state_nxt_s = state_r;
          end else if (is_sys_common(rx_data)) begin
            state_nxt_s = ST_IDLE;
          end else if (rx_data[7]) begin
            // Channel status: decoded fresh, aborting any partial message.
            if (is_note_status(rx_data) && (rx_data[3:0] == FLOPPY0_CH)) begin
              kind_nxt_s  = rx_data[4];
              tgt_nxt_s   = 1'b0;
              state_nxt_s = ST_NOTE;
            end else if (is_note_status(rx_data) && (rx_data[3:0] == FLOPPY1_CH)) begin
              kind_nxt_s  = rx_data[4];
              tgt_nxt_s   = 1'b1;
              state_nxt_s = ST_NOTE;
            end else begin
              state_nxt_s = ST_SKIP;
            end
          end else begin
            case (state_r)
              ST_NOTE: begin
                note_nxt_s  = rx_data[6:0];
                state_nxt_s = ST_VEL;
              end
              ST_VEL: begin
                // Message complete; stay in NOTE for running status.
                state_nxt_s = ST_NOTE;
                if (vel_on_s) begin
                  req_s                 = 1'b1;
                  addr_s                = {5'd0, tgt_r};
                  val_s                 = {1'b1, note_r};
                  cur_note_nxt_s[tgt_r] = note_r;
                  cur_en_nxt_s[tgt_r]   = 1'b1;
                end else if (cur_en_r[tgt_r] && (note_r == cur_note_r[tgt_r])) begin
                  req_s               = 1'b1;
                  addr_s              = {5'd0, tgt_r};
                  val_s               = {1'b0, cur_note_r[tgt_r]};
                  cur_en_nxt_s[tgt_r] = 1'b0;
                end else begin
                  req_s = 1'b0;
                end
              end
              default: begin
                // Data bytes in IDLE/SKIP carry no meaning here.
                state_nxt_s = state_r;
              end
            endcase
          end
        end else begin
          state_nxt_s = state_r;
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Parser state and per-floppy tracked note registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      kind_r     <= 1'b0;
      tgt_r      <= 1'b0;
      note_r     <= 7'd0;
      cur_note_r <= '{7'd0, 7'd0};
      cur_en_r   <= 2'b00;
    end else begin
      state_r    <= state_nxt_s;
      kind_r     <= kind_nxt_s;
      tgt_r      <= tgt_nxt_s;
      note_r     <= note_nxt_s;
      cur_note_r <= cur_note_nxt_s;
      cur_en_r   <= cur_en_nxt_s;
    end
  end

  // Registered request outputs; address/value hold between requests.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      new_req     <= 1'b0;
      write       <= 1'b0;
      reg_addr    <= 6'd0;
      write_value <= 8'd0;
    end else begin
      new_req     <= req_s;
      write       <= req_s;
      reg_addr    <= addr_s;
      write_value <= val_s;
    end
  end

endmodule

// File: tb/tb_midi_reg_master.sv
// Self-checking bench for midi_reg_master: directed scenarios plus a
// randomized byte stream checked against a message-level reference model.
module tb_midi_reg_master;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       new_rx_data = 1'b0;
  logic [5:0] reg_addr;
  logic       write;
  logic       new_req;
  logic [7:0] write_value;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int wr_glitch = 0;

  typedef struct {
    int         cyc;
    logic [5:0] addr;
    logic [7:0] val;
    logic       wr;
  } pulse_t;

  pulse_t obs_q[$];
  pulse_t exp_q[$];

  midi_reg_master #(.FLOPPY0_CH(4'd0), .FLOPPY1_CH(4'd1)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(new_rx_data),
    .reg_addr(reg_addr), .write(write), .new_req(new_req), .write_value(write_value)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every request pulse on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      if (new_req === 1'b1) begin
        pulse_t p;
        p.cyc = cyc; p.addr = reg_addr; p.val = write_value; p.wr = write;
        obs_q.push_back(p);
      end
      if (write !== new_req) wr_glitch++;
    end
  end

  // All tasks start and end at posedge+1.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] b, output int k);
    rx_data = b; new_rx_data = 1'b1; k = cyc;
    @(posedge clk); #1;
    new_rx_data = 1'b0;
  endtask

  task automatic apply_reset();
    new_rx_data = 1'b0; rx_data = 8'h00; rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(1);
    obs_q.delete();
  endtask

  // ---------------- reference model ----------------
  int         m_rs;
  bit         m_have;
  logic [6:0] m_note;
  logic [6:0] m_cur[2];
  bit         m_en[2];
  int         m_panic_end;

  function automatic void model_init();
    m_rs = -1; m_have = 0; m_note = 7'd0;
    m_cur[0] = 7'd0; m_cur[1] = 7'd0; m_en[0] = 0; m_en[1] = 0;
    m_panic_end = -10;
  endfunction

  function automatic void model_expect(input int c, input int a, input int v);
    pulse_t p;
    p.cyc = c; p.addr = 6'(a); p.val = 8'(v); p.wr = 1'b1;
    exp_q.push_back(p);
  endfunction

  function automatic void model_byte(input logic [7:0] b, input int k);
    int f, vel;
    bit on;
    if (k <= m_panic_end) return;
    if (b == 8'hFF) begin
      model_expect(k + 1, 0, 0);
      model_expect(k + 2, 1, 0);
      m_en[0] = 0; m_en[1] = 0; m_rs = -1; m_panic_end = k + 2;
    end else if (b >= 8'hF8) begin
    end else if (b >= 8'hF0) begin
      m_rs = -1;
    end else if (b >= 8'h80) begin
      m_rs = int'(b); m_have = 0;
    end else if (m_rs >= 0 && ((m_rs / 16) == 8 || (m_rs / 16) == 9) && (m_rs % 16) < 2) begin
      if (!m_have) begin
        m_note = b[6:0]; m_have = 1;
      end else begin
        m_have = 0;
        f   = m_rs % 16;
        vel = int'(b);
        on  = ((m_rs / 16) == 9) && (vel != 0);
        if (on) begin
          model_expect(k + 1, f, 128 + int'(m_note));
          m_cur[f] = m_note; m_en[f] = 1;
        end else if (m_en[f] && m_cur[f] == m_note) begin
          model_expect(k + 1, f, int'(m_note));
          m_en[f] = 0;
        end
      end
    end
  endfunction

  function automatic logic [7:0] rand_byte();
    int r;
    logic [7:0] b;
    r = int'($urandom_range(0, 99));
    if (r < 45) begin
      if ($urandom_range(0, 1) == 1) b = 8'h3C + 8'($urandom_range(0, 2));
      else if ($urandom_range(0, 3) == 0) b = 8'h00;
      else b = 8'($urandom_range(1, 127));
    end else if (r < 75) begin
      b = {3'b100, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 2))};
    end else if (r < 85) begin
      b = 8'($urandom_range(8'hA0, 8'hEF));
    end else if (r < 93) begin
      b = 8'($urandom_range(8'hF8, 8'hFE));
    end else if (r < 98) begin
      b = 8'($urandom_range(8'hF0, 8'hF7));
    end else begin
      b = 8'hFF;
    end
    return b;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #3;
    n_tests++; if (new_req !== 1'b0) begin n_fail++; $display("FAIL reset_new_req got %0b want 0", new_req); end
    n_tests++; if (write !== 1'b0) begin n_fail++; $display("FAIL reset_write got %0b want 0", write); end
    n_tests++; if (reg_addr !== 6'h00) begin n_fail++; $display("FAIL reset_addr got %h want 00", reg_addr); end
    n_tests++; if (write_value !== 8'h00) begin n_fail++; $display("FAIL reset_value got %h want 00", write_value); end
    @(posedge clk); #1;
    apply_reset();
    n_tests++; if (new_req !== 1'b0) begin n_fail++; $display("FAIL post_reset_req got %0b want 0", new_req); end
  endtask

  task automatic test_note_on();
    int k;
    obs_q.delete();
    drive(8'h90, k); drive(8'h3C, k); drive(8'h40, k);
    idle(4);
    n_tests++;
    if (obs_q.size() !== 1) begin
      n_fail++; $display("FAIL note_on_count got %0d want 1", obs_q.size());
    end else begin
      n_tests++; if (obs_q[0].cyc !== k + 1) begin n_fail++; $display("FAIL note_on_cycle got %0d want %0d", obs_q[0].cyc, k + 1); end
      n_tests++; if (obs_q[0].addr !== 6'h00) begin n_fail++; $display("FAIL note_on_addr got %h want 00", obs_q[0].addr); end
      n_tests++; if (obs_q[0].val !== 8'hBC) begin n_fail++; $display("FAIL note_on_value got %h want bc", obs_q[0].val); end
      n_tests++; if (obs_q[0].wr !== 1'b1) begin n_fail++; $display("FAIL note_on_write got %0b want 1", obs_q[0].wr); end
    end
    n_tests++; if (new_req !== 1'b0) begin n_fail++; $display("FAIL note_on_single_pulse got %0b want 0", new_req); end
  endtask

  task automatic test_running_status();
    int k1, k2;
    obs_q.delete();
    drive(8'h91, k1); drive(8'h40, k1); drive(8'h7F, k1);
    drive(8'h40, k2); drive(8'h00, k2);
    idle(4);
    n_tests++;
    if (obs_q.size() !== 2) begin
      n_fail++; $display("FAIL running_count got %0d want 2", obs_q.size());
    end else begin
      n_tests++;
      if (obs_q[0].addr !== 6'h01 || obs_q[0].val !== 8'hC0 || obs_q[0].cyc !== k1 + 1) begin
        n_fail++; $display("FAIL running_on got a=%h v=%h c=%0d want a=01 v=c0 c=%0d", obs_q[0].addr, obs_q[0].val, obs_q[0].cyc, k1 + 1);
      end
      n_tests++;
      if (obs_q[1].addr !== 6'h01 || obs_q[1].val !== 8'h40 || obs_q[1].cyc !== k2 + 1) begin
        n_fail++; $display("FAIL running_off got a=%h v=%h c=%0d want a=01 v=40 c=%0d", obs_q[1].addr, obs_q[1].val, obs_q[1].cyc, k2 + 1);
      end
    end
  endtask

  task automatic test_mismatched_off();
    int k;
    obs_q.delete();
    drive(8'h90, k); drive(8'h3C, k); drive(8'h40, k);
    drive(8'h80, k); drive(8'h3E, k); drive(8'h00, k);
    idle(4);
    n_tests++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL mismatch_count got %0d want 1", obs_q.size()); end
    obs_q.delete();
    drive(8'h80, k); drive(8'h3C, k); drive(8'h00, k);
    idle(4);
    n_tests++;
    if (obs_q.size() !== 1) begin
      n_fail++; $display("FAIL match_off_count got %0d want 1", obs_q.size());
    end else begin
      n_tests++;
      if (obs_q[0].addr !== 6'h00 || obs_q[0].val !== 8'h3C || obs_q[0].cyc !== k + 1) begin
        n_fail++; $display("FAIL match_off got a=%h v=%h c=%0d want a=00 v=3c c=%0d", obs_q[0].addr, obs_q[0].val, obs_q[0].cyc, k + 1);
      end
    end
  endtask

  task automatic test_ignore();
    int k;
    obs_q.delete();
    drive(8'h92, k); drive(8'h3C, k); drive(8'h40, k);
    drive(8'hB0, k); drive(8'h07, k); drive(8'h64, k);
    drive(8'hF0, k); drive(8'h10, k);
    drive(8'h90, k); drive(8'hF8, k); drive(8'h3C, k); drive(8'h41, k);
    idle(4);
    n_tests++;
    if (obs_q.size() !== 1) begin
      n_fail++; $display("FAIL ignore_count got %0d want 1", obs_q.size());
    end else begin
      n_tests++;
      if (obs_q[0].addr !== 6'h00 || obs_q[0].val !== 8'hBC || obs_q[0].cyc !== k + 1) begin
        n_fail++; $display("FAIL ignore_valid got a=%h v=%h c=%0d want a=00 v=bc c=%0d", obs_q[0].addr, obs_q[0].val, obs_q[0].cyc, k + 1);
      end
    end
  endtask

  task automatic test_panic();
    int k, kff;
    drive(8'h91, k); drive(8'h45, k); drive(8'h50, k);
    idle(3);
    obs_q.delete();
    drive(8'hFF, kff);
    idle(4);
    n_tests++;
    if (obs_q.size() !== 2) begin
      n_fail++; $display("FAIL panic_count got %0d want 2", obs_q.size());
    end else begin
      n_tests++;
      if (obs_q[0].addr !== 6'h00 || obs_q[0].val !== 8'h00 || obs_q[0].cyc !== kff + 1) begin
        n_fail++; $display("FAIL panic_first got a=%h v=%h c=%0d want a=00 v=00 c=%0d", obs_q[0].addr, obs_q[0].val, obs_q[0].cyc, kff + 1);
      end
      n_tests++;
      if (obs_q[1].addr !== 6'h01 || obs_q[1].val !== 8'h00 || obs_q[1].cyc !== kff + 2) begin
        n_fail++; $display("FAIL panic_second got a=%h v=%h c=%0d want a=01 v=00 c=%0d", obs_q[1].addr, obs_q[1].val, obs_q[1].cyc, kff + 2);
      end
    end
    obs_q.delete();
    drive(8'h3C, k); drive(8'h40, k);
    drive(8'h91, k); drive(8'h45, k); drive(8'h00, k);
    idle(4);
    n_tests++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL panic_after got %0d pulses want 0", obs_q.size()); end
    obs_q.delete();
    drive(8'hFF, kff); drive(8'h91, k); drive(8'h45, k); drive(8'h7F, k);
    idle(4);
    n_tests++; if (obs_q.size() !== 2) begin n_fail++; $display("FAIL panic_drop got %0d pulses want 2", obs_q.size()); end
  endtask

  task automatic test_async_reset();
    int k;
    drive(8'h90, k); drive(8'h3C, k); drive(8'h40, k);
    idle(2);
    drive(8'h91, k); drive(8'h3C, k);
    #2; rst = 1'b0; #1;
    n_tests++;
    if (new_req !== 1'b0 || write !== 1'b0 || reg_addr !== 6'h00 || write_value !== 8'h00) begin
      n_fail++; $display("FAIL async_reset_outputs got r=%0b w=%0b a=%h v=%h want all 0", new_req, write, reg_addr, write_value);
    end
    @(posedge clk); #1;
    rst = 1'b1; obs_q.delete();
    drive(8'h40, k);
    idle(4);
    n_tests++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL async_reset_msg got %0d pulses want 0", obs_q.size()); end
    drive(8'hFF, k);
    #2; rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; obs_q.delete();
    idle(3);
    drive(8'h80, k); drive(8'h3C, k); drive(8'h00, k);
    idle(4);
    n_tests++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL async_reset_panic got %0d pulses want 0", obs_q.size()); end
  endtask

  task automatic test_random();
    int k, gap, n;
    apply_reset();
    model_init();
    exp_q.delete();
    wr_glitch = 0;
    for (int i = 0; i < 600; i++) begin
      logic [7:0] b;
      b = rand_byte();
      drive(b, k);
      model_byte(b, k);
      gap = int'($urandom_range(0, 2));
      if (gap > 0) idle(gap);
    end
    idle(5);
    n_tests++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL random_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_tests++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].addr !== exp_q[i].addr ||
          obs_q[i].val !== exp_q[i].val || obs_q[i].wr !== 1'b1) begin
        n_fail++;
        $display("FAIL random_req[%0d] got c=%0d a=%h v=%h w=%0b want c=%0d a=%h v=%h w=1",
                 i, obs_q[i].cyc, obs_q[i].addr, obs_q[i].val, obs_q[i].wr,
                 exp_q[i].cyc, exp_q[i].addr, exp_q[i].val);
      end
    end
    n_tests++; if (wr_glitch !== 0) begin n_fail++; $display("FAIL write_tracks_req got %0d cycles differing want 0", wr_glitch); end
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_running_status();
    test_mismatched_off();
    test_ignore();
    test_panic();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
